// File: rtl/nn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_pkg : shared constants, Q8.8 type and driver state encoding     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nn_pkg;

  localparam int N_INPUTS    = 784;
  localparam int NUM_NEURONS = 10;
  localparam int Q8_8_W      = 16;
  localparam int SIG_W       = 8;

  typedef logic signed [Q8_8_W-1:0] q8_8_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    STORE  = 3'd4,
    DONE   = 3'd5
  } nsd_state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_stream_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | neuron_stream_driver_if : beat stream and result handshake between |
// | the driver (master) and the time-multiplexed neuron (slave)        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface neuron_stream_driver_if;
  import nn_pkg::*;

  logic             nrn_clr;
  logic             inp_ready;
  q8_8_t            inp_data;
  q8_8_t            weight;
  q8_8_t            bias;
  logic [SIG_W-1:0] sigmoid_out;
  logic             sigmoid_ready;

  modport master (
    output nrn_clr, inp_ready, inp_data, weight, bias,
    input  sigmoid_out, sigmoid_ready
  );

  modport slave (
    input  nrn_clr, inp_ready, inp_data, weight, bias,
    output sigmoid_out, sigmoid_ready
  );

endinterface
`default_nettype wire

// File: rtl/nsd_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nsd_addr_gen : beat counter, weight base accumulator and ROM       |
// | address registers for the neuron stream driver                     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module nsd_addr_gen
  import nn_pkg::*;
#(
  parameter int PIX_AW = 10,
  parameter int W_AW   = 13,
  parameter int N_AW   = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              run_start,
  input  wire logic              next_pass,
  input  wire logic [N_AW-1:0]   next_idx,
  input  wire logic              in_clr,
  input  wire logic              in_stream,
  output logic      [PIX_AW-1:0] pix_addr,
  output logic      [W_AW-1:0]   w_addr,
  output logic      [N_AW-1:0]   bias_addr,
  output logic                   beat_first,
  output logic                   beat_last
);

  localparam int                c_BEAT_W   = $clog2(N_INPUTS);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(N_INPUTS - 1);
  localparam logic [PIX_AW-1:0] c_PIX_LAST = PIX_AW'(N_INPUTS - 1);
  localparam logic [W_AW-1:0]   c_W_STEP   = W_AW'(N_INPUTS);

  logic [c_BEAT_W-1:0] r_beat;
  logic [W_AW-1:0]     r_w_base;
  logic [PIX_AW-1:0]   r_pix_addr;
  logic [W_AW-1:0]     r_w_addr;
  logic [N_AW-1:0]     r_bias_addr;
  logic [W_AW-1:0]     w_w_base_next;

  assign w_w_base_next = r_w_base + c_W_STEP;

  // Addresses lead the beat by one cycle to cover the ROM read latency,
  // so CLR presents beat 0 and the final beat simply holds its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_base    <= '0;
      r_pix_addr  <= '0;
      r_w_addr    <= '0;
      r_bias_addr <= '0;
    end else if (run_start) begin
      r_w_base    <= '0;
      r_pix_addr  <= '0;
      r_w_addr    <= '0;
      r_bias_addr <= '0;
    end else if (next_pass) begin
      r_w_base    <= w_w_base_next;
      r_pix_addr  <= '0;
      r_w_addr    <= w_w_base_next;
      r_bias_addr <= next_idx;
    end else if ((in_clr || in_stream) && (r_pix_addr != c_PIX_LAST)) begin
      r_pix_addr  <= r_pix_addr + 1'b1;
      r_w_addr    <= r_w_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat <= '0;
    end else if (in_clr) begin
      r_beat <= '0;
    end else if (in_stream && !beat_last) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign pix_addr   = r_pix_addr;
  assign w_addr     = r_w_addr;
  assign bias_addr  = r_bias_addr;
  assign beat_first = (r_beat == '0);
  assign beat_last  = (r_beat == c_BEAT_LAST);

endmodule
`default_nettype wire

// File: rtl/neuron_stream_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | neuron_stream_driver : runs NUM_NEURONS passes of one neuron and   |
// | buffers each activation. Optional argmax: NSD_ARGMAX_EN            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module neuron_stream_driver
  import nn_pkg::*;
#(
  parameter int PIX_AW  = 10,
  parameter int W_AW    = 13,
  parameter int N_AW    = 4,
  parameter int TIMEOUT = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  output logic                   busy,
  output logic                   done,
  output logic      [PIX_AW-1:0] pix_addr,
  input  wire q8_8_t             pix_rdata,
  output logic      [W_AW-1:0]   w_addr,
  input  wire q8_8_t             w_rdata,
  output logic      [N_AW-1:0]   bias_addr,
  input  wire q8_8_t             bias_rdata,
  neuron_stream_driver_if.master nrn,
  output logic                   res_we,
  output logic      [N_AW-1:0]   res_idx,
  output logic      [SIG_W-1:0]  res_data,
`ifdef NSD_ARGMAX_EN
  output logic      [N_AW-1:0]   pred_class,
`endif
  output logic                   err_timeout
);

  localparam int                c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
  localparam logic [N_AW-1:0]   c_LAST_IDX  = N_AW'(NUM_NEURONS - 1);

  nsd_state_t         r_state;
  nsd_state_t         w_next;
  logic [N_AW-1:0]    r_neuron_idx;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [SIG_W-1:0]   r_captured;
  q8_8_t              r_bias;
  logic               r_err;

  logic               w_run_start;
  logic               w_next_pass;
  logic               w_beat_first;
  logic               w_beat_last;
  logic               w_wait_last;
  logic               w_last_neuron;
  logic               w_in_clr;
  logic               w_in_stream;

  assign w_in_clr      = (r_state == CLR);
  assign w_in_stream   = (r_state == STREAM);
  assign w_wait_last   = (r_wait_cnt == c_WAIT_LAST);
  assign w_last_neuron = (r_neuron_idx == c_LAST_IDX);

  nsd_addr_gen #(
    .PIX_AW (PIX_AW),
    .W_AW   (W_AW),
    .N_AW   (N_AW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .run_start  (w_run_start),
    .next_pass  (w_next_pass),
    .next_idx   (r_neuron_idx + 1'b1),
    .in_clr     (w_in_clr),
    .in_stream  (w_in_stream),
    .pix_addr   (pix_addr),
    .w_addr     (w_addr),
    .bias_addr  (bias_addr),
    .beat_first (w_beat_first),
    .beat_last  (w_beat_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_run_start = 1'b0;
    w_next_pass = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next      = CLR;
          w_run_start = 1'b1;
        end
      end
      CLR:    w_next = STREAM;
      STREAM: if (w_beat_last) w_next = WAIT;
      WAIT:   if (nrn.sigmoid_ready || w_wait_last) w_next = STORE;
      STORE: begin
        if (w_last_neuron) begin
          w_next = DONE;
        end else begin
          w_next      = CLR;
          w_next_pass = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A response and a timeout in the same cycle resolve to the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neuron_idx <= '0;
      r_wait_cnt   <= '0;
      r_captured   <= '0;
      r_bias       <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neuron_idx <= '0;
            r_err        <= 1'b0;
          end
        end
        STREAM: begin
          r_wait_cnt <= '0;
          if (w_beat_first) r_bias <= bias_rdata;
        end
        WAIT: begin
          if (nrn.sigmoid_ready) begin
            r_captured <= nrn.sigmoid_out;
          end else if (w_wait_last) begin
            r_captured <= '0;
            r_err      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        STORE: begin
          if (!w_last_neuron) r_neuron_idx <= r_neuron_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state == CLR) || (r_state == STREAM) ||
                         (r_state == WAIT) || (r_state == STORE);
  assign done          = (r_state == DONE);
  assign res_we        = (r_state == STORE);
  assign res_idx       = r_neuron_idx;
  assign res_data      = r_captured;
  assign err_timeout   = r_err;

  assign nrn.nrn_clr   = w_in_clr;
  assign nrn.inp_ready = w_in_stream;
  assign nrn.inp_data  = w_in_stream ? pix_rdata : '0;
  assign nrn.weight    = w_in_stream ? w_rdata : '0;
  assign nrn.bias      = r_bias;

`ifdef NSD_ARGMAX_EN
  logic [SIG_W-1:0] r_max_val;
  logic [N_AW-1:0]  r_pred_class;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_val    <= '0;
      r_pred_class <= '0;
    end else if (w_run_start) begin
      r_max_val    <= '0;
      r_pred_class <= '0;
    end else if (res_we && (r_captured > r_max_val)) begin
      r_max_val    <= r_captured;
      r_pred_class <= r_neuron_idx;
    end
  end

  assign pred_class = r_pred_class;
`endif

endmodule
`default_nettype wire
